// File: rtl/ark_pkg.sv
// Shared definitions for the ark_stream AddRoundKey stage: default
// sizes, key-index width helper and the key-load status encoding.
package ark_pkg;

   localparam int unsigned ARK_NR_DEF = 10;
   localparam int unsigned ARK_W_DEF  = 128;

   // Width of a key-slot index able to address slots 0..nr.
   function automatic int unsigned ark_idx_w(input int unsigned nr);
      return (nr < 1) ? 1 : $clog2(nr + 1);
   endfunction

   typedef enum logic [1:0] {
      EMPTY,
      PARTIAL,
      LOADED
   } load_state_e;

endpackage

// File: rtl/ark_out_fifo.sv
// Output buffer for ark_stream: DEPTH-entry FIFO with wrap-around
// pointers and an explicit occupancy count. DEPTH must be a power of two.
// The head reads as zero while the FIFO is empty.
module ark_out_fifo #(
   parameter  int unsigned WIDTH = 132,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_q, wr_d;
   logic [PW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   // Next pointers, storage and count; push into a full FIFO is ignored.
   always_comb begin
      do_push = push && (cnt_q < CW'(DEPTH));
      do_pop  = pop && (cnt_q != '0);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_data;
         wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = rd_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Entry storage carries no reset; validity is tracked by the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign head  = (cnt_q != '0) ? mem_q[rd_q] : '0;

endmodule

// File: rtl/ark_stream.sv
// ark_stream: streaming AddRoundKey stage with round-key store, load
// status FSM, ready/valid input and a buffered output.
// Optional macro ARK_IDX_CHECK_EN adds the sticky err output flagging
// accepted round indices above NR (such entries use a zero key).
module ark_stream
   import ark_pkg::*;
#(
   parameter  int unsigned NR    = ARK_NR_DEF,
   parameter  int unsigned W     = ARK_W_DEF,
   parameter  int unsigned TAG_W = 4,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned IW    = ark_idx_w(NR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_wr_en,
   input  logic [IW-1:0]    key_wr_idx,
   input  logic [W-1:0]     key_wr_data,
   input  logic             key_clr,
   output logic             keys_loaded,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic [IW-1:0]    in_round,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
`ifdef ARK_IDX_CHECK_EN
   output logic [TAG_W-1:0] out_tag,
   output logic             err
`else
   output logic [TAG_W-1:0] out_tag
`endif
);

   localparam int unsigned   NK     = NR + 1;
   localparam int unsigned   CW     = $clog2(DEPTH) + 1;
   localparam logic [IW-1:0] NR_IDX = IW'(NR);

   logic [W-1:0]       key_q [NK];
   logic [W-1:0]       key_d [NK];
   logic [NK-1:0]      loaded_q, loaded_d;
   load_state_e        state_q, state_d;
   logic               wr_idx_ok;
   logic               rd_idx_ok;
   logic               accept;
   logic [W-1:0]       key_sel;
   logic [CW-1:0]      fifo_count;
   logic [W+TAG_W-1:0] fifo_head;
   logic [W+TAG_W-1:0] fifo_push_data;

   assign wr_idx_ok = (key_wr_idx <= NR_IDX);
   assign rd_idx_ok = (in_round <= NR_IDX);

   // Key writes update storage even when key_clr is active.
   always_comb begin
      key_d = key_q;
      if (key_wr_en && wr_idx_ok) begin
         key_d[key_wr_idx] = key_wr_data;
      end
   end

   // Round keys are deliberately not reset.
   always_ff @(posedge clk) begin
      key_q <= key_d;
   end

   // Loaded bitmap and load-status FSM; key_clr overrides a same-cycle write.
   always_comb begin
      loaded_d = loaded_q;
      if (key_wr_en && wr_idx_ok) begin
         loaded_d[key_wr_idx] = 1'b1;
      end
      if (key_clr) begin
         loaded_d = '0;
      end
      state_d = state_q;
      if (key_clr) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (&loaded_d) begin
                  state_d = LOADED;
               end else if (|loaded_d) begin
                  state_d = PARTIAL;
               end
            end
            PARTIAL: begin
               if (&loaded_d) begin
                  state_d = LOADED;
               end
            end
            LOADED:  state_d = LOADED;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         loaded_q <= '0;
         state_q  <= EMPTY;
      end else begin
         loaded_q <= loaded_d;
         state_q  <= state_d;
      end
   end

   assign keys_loaded = (state_q == LOADED);
   assign in_ready    = keys_loaded && (fifo_count < CW'(DEPTH));
   assign accept      = in_valid && in_ready;

   // Key lookup reads the registered key, so a same-cycle write is not seen.
   always_comb begin
      key_sel        = rd_idx_ok ? key_q[in_round] : '0;
      fifo_push_data = {in_tag, in_data ^ key_sel};
   end

`ifdef ARK_IDX_CHECK_EN
   logic err_q, err_d;

   // Sticky flag for accepted out-of-range round indices.
   always_comb begin
      err_d = err_q | (accept && !rd_idx_ok);
   end

   // Error register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   ark_out_fifo #(
      .WIDTH(W + TAG_W),
      .DEPTH(DEPTH)
   ) u_out_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_data(fifo_push_data),
      .pop      (out_ready),
      .count    (fifo_count),
      .head     (fifo_head)
   );

   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_head[W-1:0];
   assign out_tag   = fifo_head[W +: TAG_W];

endmodule

// File: tb/tb_ark_stream.sv
// Bench for ark_stream: vector table plus hand-written sequences, with a
// negedge monitor keeping a scoreboard of expected outputs and a key model.
module tb_ark_stream;

   localparam int unsigned NR    = 10;
   localparam int unsigned W     = 128;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned IW    = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             key_wr_en = 1'b0;
   logic [IW-1:0]    key_wr_idx = '0;
   logic [W-1:0]     key_wr_data = '0;
   logic             key_clr = 1'b0;
   logic             keys_loaded;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_data = '0;
   logic [IW-1:0]    in_round = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [W-1:0]     out_data;
   logic [TAG_W-1:0] out_tag;
`ifdef ARK_IDX_CHECK_EN
   logic             err;
`endif

   always #5 clk = ~clk;

   ark_stream #(
      .NR(NR),
      .W(W),
      .TAG_W(TAG_W),
      .DEPTH(DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_wr_en  (key_wr_en),
      .key_wr_idx (key_wr_idx),
      .key_wr_data(key_wr_data),
      .key_clr    (key_clr),
      .keys_loaded(keys_loaded),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_round   (in_round),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef ARK_IDX_CHECK_EN
      .out_tag    (out_tag),
      .err        (err)
`else
      .out_tag    (out_tag)
`endif
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- scoreboard monitor ----------------
   typedef struct {
      logic [W-1:0]     data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t         sb[$];
   exp_t         m_e;
   logic [W-1:0] key_m [NR+1];
   logic [NR:0]  bm_m = '0;
   logic [W-1:0] m_key;
   logic         m_rdy;

   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         bm_m = '0;
         chk("rst_out_valid", W'(out_valid), '0);
         chk("rst_in_ready", W'(in_ready), '0);
      end else begin
         m_rdy = (&bm_m) && (sb.size() < DEPTH);
         chk("mon_in_ready", W'(in_ready), W'(m_rdy));
         chk("mon_out_valid", W'(out_valid), W'(sb.size() != 0));
         chk("mon_keys_loaded", W'(keys_loaded), W'(&bm_m));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("mon_unexpected_pop", W'(1), W'(0));
            end else begin
               m_e = sb.pop_front();
               chk("sb_data", out_data, m_e.data);
               chk("sb_tag", W'(out_tag), W'(m_e.tag));
            end
         end
         if (in_valid && in_ready) begin
            m_key  = (in_round <= IW'(NR)) ? key_m[in_round] : '0;
            m_e.data = in_data ^ m_key;
            m_e.tag  = in_tag;
            sb.push_back(m_e);
         end
         if (key_wr_en) begin
            key_m[key_wr_idx] = key_wr_data;
            bm_m[key_wr_idx]  = 1'b1;
         end
         if (key_clr) begin
            bm_m = '0;
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      logic [IW-1:0]    rnd;
      logic [W-1:0]     data;
      logic [TAG_W-1:0] tag;
      logic [W-1:0]     exp;
   } vec_t;

   logic [W-1:0] key_tab [NR+1];
   vec_t         tab [6];
   int unsigned  acc;
   logic [W-1:0] x, y, k2, k0n;

   initial begin
      for (int i = 0; i <= NR; i++) key_tab[i] = rnd128();
      key_tab[1] = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

      tab[0].rnd = 4'd1;  tab[0].data = 128'h5f72641557f5bc92f7be3b291db9f91a;
      tab[0].tag = 4'd3;  tab[0].exp  = 128'h89d810e8855ace682d1843d8cb128fe4;
      tab[1].rnd = 4'd0;  tab[1].data = rnd128();   tab[1].tag = 4'd5;
      tab[2].rnd = 4'd10; tab[2].data = rnd128();   tab[2].tag = 4'd15;
      tab[3].rnd = 4'd5;  tab[3].data = rnd128();   tab[3].tag = 4'd0;
      tab[4].rnd = 4'd1;  tab[4].data = '1;         tab[4].tag = 4'd9;
      tab[5].rnd = 4'd10; tab[5].data = '0;         tab[5].tag = 4'd12;
      for (int i = 1; i < 6; i++) tab[i].exp = tab[i].data ^ key_tab[tab[i].rnd];

      // reset values
      tick();
      tick();
      chk("reset_in_ready", W'(in_ready), '0);
      chk("reset_out_valid", W'(out_valid), '0);
      chk("reset_keys_loaded", W'(keys_loaded), '0);
      chk("reset_out_data", out_data, '0);
      chk("reset_out_tag", W'(out_tag), '0);
`ifdef ARK_IDX_CHECK_EN
      chk("reset_err", W'(err), '0);
`endif
      reset = 1'b0;
      tick();

      // load all slots on consecutive cycles
      for (int i = 0; i <= NR; i++) begin
         key_wr_en   = 1'b1;
         key_wr_idx  = IW'(i);
         key_wr_data = key_tab[i];
         tick();
         if (i < NR) chk("load_partial", W'(keys_loaded), '0);
      end
      key_wr_en = 1'b0;
      chk("load_complete", W'(keys_loaded), W'(1));
      chk("load_in_ready", W'(in_ready), W'(1));

      // vector table, one state per cycle with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_round = tab[i].rnd;
         in_data  = tab[i].data;
         in_tag   = tab[i].tag;
         tick();
         chk("vec_out_valid", W'(out_valid), W'(1));
         chk("vec_out_data", out_data, tab[i].exp);
         chk("vec_out_tag", W'(out_tag), W'(tab[i].tag));
      end
      in_valid = 1'b0;
      tick();
      chk("vec_drained", W'(out_valid), '0);

      // backpressure: exactly DEPTH accepts, then in_ready low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      acc = 0;
      for (int c = 0; c < DEPTH + 3; c++) begin
         in_data  = rnd128();
         in_round = IW'($urandom_range(0, NR));
         in_tag   = TAG_W'(c);
         if (in_ready) acc++;
         tick();
      end
      chk("bp_accepts", W'(acc), W'(DEPTH));
      chk("bp_in_ready", W'(in_ready), '0);
      out_ready = 1'b1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_data  = rnd128();
         in_round = IW'($urandom_range(0, NR));
         in_tag   = TAG_W'(c + 8);
         if (in_ready) acc++;
         tick();
      end
      chk("thru_accepts", W'(acc), W'(5));
      in_valid = 1'b0;
      repeat (DEPTH + 1) tick();
      chk("thru_drained", W'(out_valid), '0);

      // accept and key rewrite of the same slot in the same cycle
      x  = rnd128();
      y  = rnd128();
      k2 = rnd128();
      in_valid    = 1'b1;
      in_round    = 4'd1;
      in_data     = x;
      in_tag      = 4'd6;
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'd1;
      key_wr_data = k2;
      tick();
      chk("rbw_old_key", out_data, x ^ key_tab[1]);
      key_wr_en  = 1'b0;
      key_tab[1] = k2;
      in_data    = y;
      in_tag     = 4'd7;
      tick();
      chk("rbw_new_key", out_data, y ^ k2);
      in_valid = 1'b0;
      tick();

      // key_clr with two results buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_round  = 4'd3;
      in_data   = rnd128();
      in_tag    = 4'd1;
      tick();
      in_data = rnd128();
      in_tag  = 4'd2;
      tick();
      in_valid = 1'b0;
      key_clr  = 1'b1;
      tick();
      key_clr = 1'b0;
      chk("clr_in_ready", W'(in_ready), '0);
      chk("clr_keys_loaded", W'(keys_loaded), '0);
      chk("clr_buffered", W'(out_valid), W'(1));
      out_ready = 1'b1;
      tick();
      tick();
      chk("clr_drained", W'(out_valid), '0);

      // key_clr wins the bitmap over a same-cycle write, data still lands
      k0n         = rnd128();
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'd0;
      key_wr_data = k0n;
      key_clr     = 1'b1;
      tick();
      key_clr = 1'b0;
      key_tab[0] = k0n;
      for (int i = 1; i <= NR; i++) begin
         key_wr_idx  = IW'(i);
         key_wr_data = key_tab[i];
         tick();
      end
      key_wr_en = 1'b0;
      chk("clr_wins_loaded", W'(keys_loaded), '0);
      chk("clr_wins_in_ready", W'(in_ready), '0);
      in_valid = 1'b1;
      in_round = 4'd0;
      x        = rnd128();
      in_data  = x;
      in_tag   = 4'd4;
      tick();
      chk("clr_wins_no_accept", W'(out_valid), '0);
      in_valid    = 1'b0;
      key_wr_en   = 1'b1;
      key_wr_idx  = 4'd0;
      key_wr_data = k0n;
      tick();
      key_wr_en = 1'b0;
      chk("reload_loaded", W'(keys_loaded), W'(1));
      in_valid = 1'b1;
      tick();
      chk("clr_write_kept", out_data, x ^ k0n);
      in_valid = 1'b0;
      tick();

`ifdef ARK_IDX_CHECK_EN
      // out-of-range round index
      chk("err_before", W'(err), '0);
      x        = rnd128();
      in_valid = 1'b1;
      in_round = 4'd12;
      in_data  = x;
      in_tag   = 4'd9;
      tick();
      in_valid = 1'b0;
      chk("err_set", W'(err), W'(1));
      chk("err_data", out_data, x);
      tick();
      tick();
      chk("err_sticky", W'(err), W'(1));
`endif

      // reset mid-operation discards buffered results immediately
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_round  = 4'd2;
      in_data   = rnd128();
      in_tag    = 4'd11;
      tick();
      tick();
      in_valid = 1'b0;
      chk("pre_rst_full", W'(out_valid), W'(1));
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", W'(out_valid), '0);
      chk("mid_rst_out_data", out_data, '0);
      chk("mid_rst_out_tag", W'(out_tag), '0);
      chk("mid_rst_in_ready", W'(in_ready), '0);
      chk("mid_rst_keys_loaded", W'(keys_loaded), '0);
`ifdef ARK_IDX_CHECK_EN
      chk("mid_rst_err", W'(err), '0);
`endif
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_out_valid", W'(out_valid), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
